// File: rtl/sram16_word_bridge.sv
// Bridges one 32-bit big-endian word access onto a 16-bit asynchronous SRAM
// as up to two halfword cycles (hi half at the even address, lo half at the odd one).
module sram16_word_bridge #(
  parameter int AW          = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          REQ,
  input  logic          WE,
  input  logic [AW-2:0] WORD_ADDR,
  input  logic [3:0]    BYTE_EN,
  input  logic [31:0]   WDATA,
  output logic [31:0]   RDATA,
  output logic          ACK,
  output logic          BUSY,
  output logic [AW-1:0] SRAM_ADDR,
  input  logic [15:0]   SRAM_DQ_IN,
  output logic [15:0]   SRAM_DQ_OUT,
  output logic          SRAM_DQ_OE,
  output logic          SRAM_CE_N,
  output logic          SRAM_OE_N,
  output logic          SRAM_WE_N,
  output logic          SRAM_UB_N,
  output logic          SRAM_LB_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t        state;
  logic          half;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [AW-2:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [15:0]   rd_hi;
  logic [15:0]   rd_lo;

  logic          zero_write;
  logic          need_lo;
  logic          enter_setup;
  logic          setup_half;
  logic          setup_we;
  logic [AW-2:0] setup_addr;
  logic [1:0]    setup_lanes;
  logic [15:0]   setup_dq;

  assign zero_write  = WE && (BYTE_EN == 4'b0000);
  assign need_lo     = !we_q || (be_q[1:0] != 2'b00);
  assign enter_setup = ((state == IDLE) && REQ && !zero_write) ||
                       ((state == HOLD) && !half && need_lo);

  // Pad values for the half about to start: from the live request when
  // accepting, otherwise the second (lo) half of the latched access.
  always_comb begin
    setup_half  = 1'b1;
    setup_we    = we_q;
    setup_addr  = addr_q;
    setup_lanes = be_q[1:0];
    setup_dq    = wdata_q[15:0];
    if (state == IDLE) begin
      setup_we    = WE;
      setup_addr  = WORD_ADDR;
      setup_half  = WE && (BYTE_EN[3:2] == 2'b00);
      setup_lanes = setup_half ? BYTE_EN[1:0] : BYTE_EN[3:2];
      setup_dq    = setup_half ? WDATA[15:0] : WDATA[31:16];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      half        <= 1'b0;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rd_hi       <= '0;
      rd_lo       <= '0;
      RDATA       <= '0;
      ACK         <= 1'b0;
      BUSY        <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
    end else begin
      ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            we_q    <= WE;
            addr_q  <= WORD_ADDR;
            be_q    <= BYTE_EN;
            wdata_q <= WDATA;
            BUSY    <= 1'b1;
            if (zero_write) begin
              state <= DONE;
              ACK   <= 1'b1;
            end else begin
              state <= SETUP;
              half  <= setup_half;
            end
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CNT_INIT;
          if (we_q) SRAM_WE_N <= 1'b0;
        end
        STROBE: begin
          if (cnt == '0) begin
            state     <= HOLD;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            if (!we_q) begin
              if (half) rd_lo <= SRAM_DQ_IN;
              else      rd_hi <= SRAM_DQ_IN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (!half && need_lo) begin
            state <= SETUP;
            half  <= 1'b1;
          end else begin
            state      <= DONE;
            ACK        <= 1'b1;
            SRAM_CE_N  <= 1'b1;
            SRAM_UB_N  <= 1'b1;
            SRAM_LB_N  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
            if (!we_q) RDATA <= {rd_hi, rd_lo};
          end
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase

      // Drive address, strobes and data for the half entering SETUP.
      if (enter_setup) begin
        SRAM_ADDR <= {setup_addr, setup_half};
        SRAM_CE_N <= 1'b0;
        SRAM_WE_N <= 1'b1;
        if (setup_we) begin
          SRAM_DQ_OE  <= 1'b1;
          SRAM_DQ_OUT <= setup_dq;
          SRAM_UB_N   <= ~setup_lanes[1];
          SRAM_LB_N   <= ~setup_lanes[0];
          SRAM_OE_N   <= 1'b1;
        end else begin
          SRAM_DQ_OE <= 1'b0;
          SRAM_UB_N  <= 1'b0;
          SRAM_LB_N  <= 1'b0;
          SRAM_OE_N  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram16_word_bridge.sv
// Drives a WAIT_CYCLES=2 and a WAIT_CYCLES=1 bridge in parallel against a
// halfword SRAM model and a word-level reference memory.
module tb_sram16_word_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_n     [2];
  logic        req       [2];
  logic        we        [2];
  logic [18:0] word_addr [2];
  logic [3:0]  byte_en   [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic        ack       [2];
  logic        busy      [2];
  logic [19:0] sram_addr [2];
  logic [15:0] dq_in     [2];
  logic [15:0] dq_out    [2];
  logic        dq_oe     [2];
  logic        ce_n      [2];
  logic        oe_n      [2];
  logic        we_n      [2];
  logic        ub_n      [2];
  logic        lb_n      [2];

  logic [31:0] init_words [128];
  logic [31:0] ref_mem    [2][128];
  logic [31:0] last_read  [2];
  logic [15:0] smem       [2][256];
  logic        mem_ready;
  logic        cur_we     [2];
  int          we_cnt     [2];
  int          oe_cnt     [2];
  int          ce_cnt     [2];
  int          viol       [2];

  sram16_word_bridge #(.AW(20), .WAIT_CYCLES(2)) u_dut_w2 (
    .CLK(clk), .RESET_N(rst_n[0]), .REQ(req[0]), .WE(we[0]),
    .WORD_ADDR(word_addr[0]), .BYTE_EN(byte_en[0]), .WDATA(wdata[0]),
    .RDATA(rdata[0]), .ACK(ack[0]), .BUSY(busy[0]), .SRAM_ADDR(sram_addr[0]),
    .SRAM_DQ_IN(dq_in[0]), .SRAM_DQ_OUT(dq_out[0]), .SRAM_DQ_OE(dq_oe[0]),
    .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0]), .SRAM_WE_N(we_n[0]),
    .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0])
  );

  sram16_word_bridge #(.AW(20), .WAIT_CYCLES(1)) u_dut_w1 (
    .CLK(clk), .RESET_N(rst_n[1]), .REQ(req[1]), .WE(we[1]),
    .WORD_ADDR(word_addr[1]), .BYTE_EN(byte_en[1]), .WDATA(wdata[1]),
    .RDATA(rdata[1]), .ACK(ack[1]), .BUSY(busy[1]), .SRAM_ADDR(sram_addr[1]),
    .SRAM_DQ_IN(dq_in[1]), .SRAM_DQ_OUT(dq_out[1]), .SRAM_DQ_OE(dq_oe[1]),
    .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1]), .SRAM_WE_N(we_n[1]),
    .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1])
  );

  assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? smem[0][sram_addr[0][7:0]] : 16'hBAD0;
  assign dq_in[1] = (!ce_n[1] && !oe_n[1]) ? smem[1][sram_addr[1][7:0]] : 16'hBAD1;

  // SRAM model plus strobe activity counters and protocol-violation tally.
  always @(posedge clk) begin
    if (mem_ready !== 1'b1) begin
      for (int i = 0; i < 128; i++) begin
        for (int g = 0; g < 2; g++) begin
          smem[g][2*i]   <= init_words[i][31:16];
          smem[g][2*i+1] <= init_words[i][15:0];
        end
      end
      mem_ready <= 1'b1;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (!ce_n[g] && !we_n[g] && dq_oe[g]) begin
          if (!ub_n[g]) smem[g][sram_addr[g][7:0]][15:8] <= dq_out[g][15:8];
          if (!lb_n[g]) smem[g][sram_addr[g][7:0]][7:0]  <= dq_out[g][7:0];
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      if (!we_n[g]) we_cnt[g] <= we_cnt[g] + 1;
      if (!oe_n[g]) oe_cnt[g] <= oe_cnt[g] + 1;
      if (!ce_n[g]) ce_cnt[g] <= ce_cnt[g] + 1;
      if ((!we_n[g] && !oe_n[g]) ||
          (dq_oe[g] && (ce_n[g] || !cur_we[g])) ||
          (!ce_n[g] && (sram_addr[g][19:8] != 12'h000)) ||
          (!busy[g] && (!ce_n[g] || !we_n[g] || !oe_n[g] || dq_oe[g])))
        viol[g] <= viol[g] + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic int halves_touched(input logic w, input logic [3:0] be);
    if (!w) return 2;
    return int'(be[3:2] != 2'b00) + int'(be[1:0] != 2'b00);
  endfunction

  task automatic run_txn(input int g, input int wc, input logic w, input logic [18:0] a,
                         input logic [3:0] be, input logic [31:0] wd,
                         input bit keep_req, input bit already);
    int nh, exp_lat, lat, we0, oe0, ce0, v0;
    logic [31:0] obs_rdata;
    nh      = halves_touched(w, be);
    exp_lat = (nh == 0) ? 1 : nh * (wc + 2) + 1;
    obs_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    if (!already) begin
      we[g] = w; word_addr[g] = a; byte_en[g] = be; wdata[g] = wd; req[g] = 1'b1;
    end
    cur_we[g] = w;
    check_output($sformatf("w%0d idle_before", wc), 32'(busy[g]), 32'h0);
    we0 = we_cnt[g]; oe0 = oe_cnt[g]; ce0 = ce_cnt[g]; v0 = viol[g];
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ack[g]) begin
        lat = k;
        obs_rdata = rdata[g];
        req[g] = keep_req;
        break;
      end
      req[g] = 1'($urandom_range(0, 1));
    end
    if (lat == 0) req[g] = 1'b0;
    if (w) ref_mem[g][a[6:0]] = merge_bytes(ref_mem[g][a[6:0]], wd, be);
    else   last_read[g] = ref_mem[g][a[6:0]];
    check_output($sformatf("w%0d ack_latency", wc), 32'(lat), 32'(exp_lat));
    check_output($sformatf("w%0d rdata", wc), obs_rdata, last_read[g]);
    if (w) begin
      check_output($sformatf("w%0d mem_hi", wc), {16'h0, smem[g][{a[6:0], 1'b0}]},
                   {16'h0, ref_mem[g][a[6:0]][31:16]});
      check_output($sformatf("w%0d mem_lo", wc), {16'h0, smem[g][{a[6:0], 1'b1}]},
                   {16'h0, ref_mem[g][a[6:0]][15:0]});
    end
    check_output($sformatf("w%0d we_cycles", wc), 32'(we_cnt[g] - we0), w ? 32'(nh * wc) : 32'h0);
    check_output($sformatf("w%0d oe_cycles", wc), 32'(oe_cnt[g] - oe0), w ? 32'h0 : 32'(2 * (wc + 1)));
    check_output($sformatf("w%0d ce_cycles", wc), 32'(ce_cnt[g] - ce0), 32'(nh * (wc + 2)));
    check_output($sformatf("w%0d protocol", wc), 32'(viol[g] - v0), 32'h0);
  endtask

  task automatic reset_mid_write(input int g, input int wc);
    int we0, ce0;
    @(negedge clk);
    we[g] = 1'b1; word_addr[g] = 19'h30; byte_en[g] = 4'hF; wdata[g] = $urandom; req[g] = 1'b1;
    cur_we[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[g] = 1'b0;
    @(negedge clk);
    check_output($sformatf("w%0d rst_in_strobe", wc), 32'(we_n[g]), 32'h0);
    #1 rst_n[g] = 1'b0;
    #1;
    check_output($sformatf("w%0d rst_strobes", wc),
                 {26'h0, ce_n[g], oe_n[g], we_n[g], ub_n[g], lb_n[g], dq_oe[g]}, 32'h3E);
    check_output($sformatf("w%0d rst_addr", wc), 32'(sram_addr[g]), 32'h0);
    check_output($sformatf("w%0d rst_dq_out", wc), 32'(dq_out[g]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n[g] = 1'b1;
    we0 = we_cnt[g]; ce0 = ce_cnt[g];
    repeat (4) @(negedge clk);
    last_read[g] = 32'h0;
    check_output($sformatf("w%0d post_rst_busy", wc), 32'(busy[g]), 32'h0);
    check_output($sformatf("w%0d post_rst_ack", wc), 32'(ack[g]), 32'h0);
    check_output($sformatf("w%0d post_rst_rdata", wc), rdata[g], 32'h0);
    check_output($sformatf("w%0d post_rst_ce", wc), 32'(ce_cnt[g] - ce0), 32'h0);
    check_output($sformatf("w%0d post_rst_we", wc), 32'(we_cnt[g] - we0), 32'h0);
    check_output($sformatf("w%0d post_rst_mem_lo", wc), {16'h0, smem[g][8'h61]},
                 {16'h0, ref_mem[g][7'h30][15:0]});
  endtask

  task automatic apply_stimulus(input int g, input int wc);
    for (int i = 0; i < 128; i++) ref_mem[g][i] = init_words[i];
    last_read[g] = 32'h0;
    run_txn(g, wc, 1'b1, 19'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    check_output($sformatf("w%0d full_wr_h", wc), {16'h0, smem[g][8'h20]}, 32'h0000DEAD);
    check_output($sformatf("w%0d full_wr_l", wc), {16'h0, smem[g][8'h21]}, 32'h0000BEEF);
    run_txn(g, wc, 1'b1, 19'h10, 4'b0010, 32'h0000AB00, 1'b0, 1'b0);
    check_output($sformatf("w%0d byte_wr_h", wc), {16'h0, smem[g][8'h20]}, 32'h0000DEAD);
    check_output($sformatf("w%0d byte_wr_l", wc), {16'h0, smem[g][8'h21]}, 32'h0000ABEF);
    run_txn(g, wc, 1'b0, 19'h10, 4'h0, 32'h0, 1'b0, 1'b0);
    run_txn(g, wc, 1'b0, 19'h20, 4'hF, 32'h0, 1'b0, 1'b0);
    run_txn(g, wc, 1'b1, 19'h05, 4'h0, $urandom, 1'b0, 1'b0);
    run_txn(g, wc, 1'b0, 19'h20, 4'h0, 32'h0, 1'b1, 1'b0);
    run_txn(g, wc, 1'b0, 19'h20, 4'h0, 32'h0, 1'b0, 1'b1);
    repeat (30) begin
      run_txn(g, wc, 1'($urandom_range(0, 1)), 19'($urandom_range(0, 127)),
              4'($urandom), $urandom, 1'b0, 1'b0);
    end
    reset_mid_write(g, wc);
    repeat (6) begin
      run_txn(g, wc, 1'($urandom_range(0, 1)), 19'($urandom_range(0, 127)),
              4'($urandom), $urandom, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) init_words[i] = $urandom;
    init_words[32] = 32'h12345678;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; req[g] = 1'b0; we[g] = 1'b0; word_addr[g] = '0;
      byte_en[g] = '0; wdata[g] = '0; cur_we[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_output($sformatf("dut%0d reset_rdata", g), rdata[g], 32'h0);
      check_output($sformatf("dut%0d reset_ack_busy", g), {30'h0, ack[g], busy[g]}, 32'h0);
      check_output($sformatf("dut%0d reset_strobes", g),
                   {26'h0, ce_n[g], oe_n[g], we_n[g], ub_n[g], lb_n[g], dq_oe[g]}, 32'h3E);
      check_output($sformatf("dut%0d reset_addr", g), 32'(sram_addr[g]), 32'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    fork
      apply_stimulus(0, 2);
      apply_stimulus(1, 1);
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
